// File: rtl/rv_fetch_unit_if.sv
// Instruction-memory request/response bundle for rv_fetch_unit.
//   imem_req   : fetch request, held until acknowledged
//   imem_addr  : word address of the request, stable while imem_req is high
//   imem_ack   : response valid this cycle (only meaningful with imem_req high)
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch unit side, slave = instruction memory side.
interface rv_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32I instruction fetch front end.
// Issues word fetches over a req/ack handshake, buffers returned words with
// their PCs in a DEPTH-entry FIFO and presents the head entry with its
// decoded opcode/register/funct fields. Redirects flush the buffer; a request
// still outstanding at redirect time is drained and its data discarded.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction memory bundle (rv_fetch_unit_if.master)
//   redirect_valid  : redirect fetch to redirect_pc (bits [1:0] ignored)
//   stall           : consumer not ready, no pop this cycle
//   instr_valid     : head of buffer valid
//   instr, instr_pc : head word and its address (0 when empty)
//   opcode, rd, rs1, rs2, funct3, funct7 : field slices of instr
//   illegal         : head opcode outside the supported RV32I subset
//
// Build option: define RV_FETCH_ILLEGAL_CHECK_EN to enable the opcode check;
// when undefined, illegal is tied to 0.
module rv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rv_fetch_unit_if.master       imem,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  stall,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic [6:0]            opcode,
  output logic [4:0]            rd,
  output logic [4:0]            rs1,
  output logic [4:0]            rs2,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic                  illegal
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   word_d [DEPTH];
  logic [31:0]   epc_q  [DEPTH];
  logic [31:0]   epc_d  [DEPTH];
  logic          push, pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    word_d  = word_q;
    epc_d   = epc_q;
    push    = (state_q == REQ) && imem.imem_ack;
    pop     = (count_q != '0) && !stall;

    if (redirect_valid) begin
      // Flush wins over any push/pop on this edge.
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      if ((state_q == REQ || state_q == DRAIN) && !imem.imem_ack) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end else begin
      if (push) begin
        word_d[wptr_q] = imem.imem_rdata;
        epc_d[wptr_q]  = pc_q;
        wptr_d         = wptr_q + AW'(1'b1);
        pc_d           = pc_q + 32'd4;
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1'b1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     if (push && count_d == DEPTH_C) state_d = WAIT;
        WAIT:    if (count_d < DEPTH_C) state_d = REQ;
        DRAIN:   if (imem.imem_ack) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end

    req_d  = (state_d == REQ) || (state_d == DRAIN);
    // DRAIN keeps presenting the abandoned address until it is acknowledged.
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      word_q  <= '{default: '0};
      epc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      word_q  <= word_d;
      epc_q   <= epc_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? word_q[rptr_q] : '0;
  assign instr_pc    = instr_valid ? epc_q[rptr_q]  : '0;
  assign opcode      = instr[6:0];
  assign rd          = instr[11:7];
  assign funct3      = instr[14:12];
  assign rs1         = instr[19:15];
  assign rs2         = instr[24:20];
  assign funct7      = instr[31:25];

`ifdef RV_FETCH_ILLEGAL_CHECK_EN
  always_comb begin
    case (opcode)
      7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111,
      7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111: illegal = 1'b0;
      default:                                         illegal = instr_valid;
    endcase
  end
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: doc/rv_fetch_unit.md
# rv_fetch_unit

Instruction fetch front end for the RV32I single-cycle core. It is the producer side of the instruction fields that the main and ALU controllers decode. It issues word requests to instruction memory with a req/ack handshake and buffers returned words in a small FIFO. It presents each instruction with its PC and pre-split opcode/funct/register fields, and handles PC redirects from branch/jal/jalr resolution by flushing and draining.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, instruction buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request; held until acked
- imem_addr  out  32  word address of request; stable while imem_req high
- imem_ack  in  1  response valid this cycle, sampled with imem_req high
- imem_rdata  in  32  instruction word, valid with imem_ack
- redirect_valid  in  1  redirect fetch to redirect_pc (branch taken, jal, jalr)
- redirect_pc  in  32  new PC; bits [1:0] ignored, treated as 0
- stall  in  1  consumer not ready; no pop this cycle
- instr_valid  out  1  head of buffer is valid
- instr  out  32  head instruction word
- instr_pc  out  32  address of head instruction
- opcode  out  7  instr[6:0]
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- illegal  out  1  head opcode outside supported set

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: entered on reset; pc=RESET_PC; next cycle → REQ.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: push {imem_rdata, pc}; pc←pc+4 (wraps 0xFFFF_FFFC→0). Stay in REQ if post-edge count<DEPTH, else → WAIT.
- WAIT: imem_req=0. → REQ when count<DEPTH.
- REQ is entered only with count<DEPTH. Count cannot grow while a request is outstanding, so an ack always has space; no overflow case exists.
- Pop: instr_valid && !stall at edge removes head. Pop and push in the same cycle leave count unchanged.
- Redirect, highest priority at its edge:
  - FIFO cleared; pop and push that edge are discarded.
  - pc←{redirect_pc[31:2],2'b00}.
  - From REQ without imem_ack that cycle → DRAIN; otherwise → REQ.
- DRAIN: imem_req stays high with the old address (protocol: no request withdrawal). On imem_ack, data is discarded → REQ at the redirected pc. A second redirect in DRAIN only updates pc.
- Supported opcodes: 0110011, 0000011, 0010011, 1100111, 0100011, 1100011, 0110111, 1101111. illegal=instr_valid && opcode not in set.
- Field outputs are combinational slices of the head entry. When empty, they are 0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, all fields 0, illegal=0, count=0, state=IDLE.
- rst held: state stays IDLE, no request.
- rst mid-transaction: outstanding request abandoned; memory side must tolerate withdrawal on reset only.
- Reset→first imem_req: 1 cycle after rst falls (IDLE cycle).
- Ack→instr_valid: 1 cycle (registered FIFO, no bypass).
- Zero-wait memory (ack same cycle as req): one instruction per cycle sustained when never stalled.
- Redirect with no outstanding request: new imem_addr visible the cycle after the redirect edge.
- Redirect in DRAIN: pays remaining old-request latency plus 1 cycle.

## Configuration
- RV_FETCH_ILLEGAL_CHECK_EN defined: illegal computed as above.
- RV_FETCH_ILLEGAL_CHECK_EN undefined: illegal tied to 0; opcode compare logic removed. All other behaviour unchanged.

## Test plan
- Reset then zero-wait memory returning addr-as-data, stall=0 → imem_addr 0,4,8,…; instr_valid from cycle 2; instr_pc 0,4,8 consecutively with no bubbles.
- stall=1 held for 6 cycles, DEPTH=2 → exactly two pushes, then imem_req=0 (WAIT). On stall release, instrs at PC 0,4 pop in order, then fetch resumes at 8.
- Memory ack delayed 3 cycles. Redirect to 0x100 one cycle after req to 0x8 → req stays at 0x8 until ack, data discarded. Next req addr 0x100; first valid instr_pc=0x100.
- Redirect to 0x203 coinciding with ack and pop → FIFO empty next cycle. No DRAIN; next imem_addr=0x200.
- RESET_PC=32'hFFFF_FFF8, zero-wait → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- imem_rdata=32'h0000_007F (opcode 1111111) → illegal=1 with macro defined, 0 without. imem_rdata=32'h0000_0063 (branch) → illegal=0.
